// File: rtl/inv_decision_filter_if.sv
// Signal bundle between the inverter-pair sense front end and the decision filter.
// The driver side (config/analog stimulus) uses master; the filter uses slave.
interface inv_decision_filter_if;
    logic ENABLE;
    logic RELOCK;
    logic RAW_INVU;
    logic RAW_INVD;
    logic O_INVU;
    logic O_INVD;
    logic STEP;
    logic LOCKED;

    modport master (
        output ENABLE, RELOCK, RAW_INVU, RAW_INVD,
        input  O_INVU, O_INVD, STEP, LOCKED
    );

    modport slave (
        input  ENABLE, RELOCK, RAW_INVU, RAW_INVD,
        output O_INVU, O_INVD, STEP, LOCKED
    );
endinterface

// File: rtl/inv_decision_filter.sv
// Inverter-pair decision filter: synchronises the raw INVU/INVD comparator
// outputs, tallies them over a 2^WIN_BITS window, majority-votes a one-hot
// decision, strobes STEP once per decision and freezes once the adjustment
// has reversed direction LOCK_CNT times in a row.
module inv_decision_filter #(
    parameter int WIN_BITS = 4,
    parameter int SETTLE   = 16,
    parameter int LOCK_CNT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    inv_decision_filter_if.slave  bus
);

    // One counter serves both the settle wait and the sample window.
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW = (SW > WIN_BITS) ? SW : WIN_BITS;
    // Tally holds up to 2^WIN_BITS, so one extra bit avoids overflow.
    localparam int TW = WIN_BITS + 1;
    // Reversal count never exceeds LOCK_CNT (reaching it locks).
    localparam int RW = (LOCK_CNT > 0) ? $clog2(LOCK_CNT + 1) : 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] WIN_LAST    = CW'((1 << WIN_BITS) - 1);
    localparam logic [RW-1:0] REV_LOCK    = RW'(LOCK_CNT);

    typedef enum logic [2:0] {
        S_SETTLE = 3'd0,
        S_SAMPLE = 3'd1,
        S_DECIDE = 3'd2,
        S_STEP   = 3'd3,
        S_LOCK   = 3'd4
    } state_t;

    state_t          state_q,   state_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [TW-1:0]   tally_u_q, tally_u_d;
    logic [TW-1:0]   tally_d_q, tally_d_d;
    logic [RW-1:0]   rev_q,     rev_d;
    logic            pvld_q,    pvld_d;
    logic            dec_q,     dec_d;      // 1 = INVU dominant, 0 = INVD dominant
    logic            step_q,    step_d;
    logic            locked_q,  locked_d;
    // bit 1 = INVU side, bit 0 = INVD side
    logic [1:0]      sync1_q,   sync1_d;
    logic [1:0]      sync2_q,   sync2_d;

    logic            dec_new;
    logic            tie;
    logic [RW-1:0]   rev_nxt;

    assign dec_new = (tally_u_q > tally_d_q);
    assign tie     = (tally_u_q == tally_d_q);

    // Next-state, counters, tallies and decision bookkeeping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tally_u_d = tally_u_q;
        tally_d_d = tally_d_q;
        rev_d     = rev_q;
        pvld_d    = pvld_q;
        dec_d     = dec_q;
        rev_nxt   = '0;
        sync1_d   = {bus.RAW_INVU, bus.RAW_INVD};
        sync2_d   = sync1_q;

        if (state_q == S_LOCK) begin
            // Frozen until explicitly released; ENABLE has no effect here.
            if (bus.RELOCK) begin
                state_d = S_SETTLE;
                cnt_d   = '0;
                rev_d   = '0;
                pvld_d  = 1'b0;
            end
        end else if (!bus.ENABLE) begin
            // Abort whatever is in flight, including a pending decision.
            state_d   = S_SETTLE;
            cnt_d     = '0;
            tally_u_d = '0;
            tally_d_d = '0;
        end else begin
            unique case (state_q)
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d     = '0;
                        tally_u_d = '0;
                        tally_d_d = '0;
                        state_d   = S_SAMPLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    tally_u_d = tally_u_q + TW'(sync2_q[1]);
                    tally_d_d = tally_d_q + TW'(sync2_q[0]);
                    if (cnt_q == WIN_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DECIDE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DECIDE: begin
                    if (tie) begin
                        // No evidence either way: resample immediately.
                        tally_u_d = '0;
                        tally_d_d = '0;
                        state_d   = S_SAMPLE;
                    end else begin
                        if (pvld_q && (dec_new != dec_q))
                            rev_nxt = rev_q + 1'b1;
                        else
                            rev_nxt = '0;
                        rev_d  = rev_nxt;
                        pvld_d = 1'b1;
                        dec_d  = dec_new;
                        cnt_d  = '0;
                        state_d = (rev_nxt == REV_LOCK) ? S_LOCK : S_STEP;
                    end
                end
                S_STEP: begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            endcase
        end

        // Both strobes are registered copies of the state being entered.
        step_d   = (state_d == S_STEP);
        locked_d = (state_d == S_LOCK);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_SETTLE;
            cnt_q     <= '0;
            tally_u_q <= '0;
            tally_d_q <= '0;
            rev_q     <= '0;
            pvld_q    <= 1'b0;
            dec_q     <= 1'b1;
            step_q    <= 1'b0;
            locked_q  <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tally_u_q <= tally_u_d;
            tally_d_q <= tally_d_d;
            rev_q     <= rev_d;
            pvld_q    <= pvld_d;
            dec_q     <= dec_d;
            step_q    <= step_d;
            locked_q  <= locked_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
        end
    end

    // A single decision bit drives both outputs, so they are one-hot by construction.
    assign bus.O_INVU = dec_q;
    assign bus.O_INVD = ~dec_q;
    assign bus.STEP   = step_q;
    assign bus.LOCKED = locked_q;

endmodule

// File: tb/tb_inv_decision_filter.sv
// Bench for inv_decision_filter: directed vector table, hand-written lock /
// relock / reset sequences, and a long randomized run against a window-level
// reference model.
module tb_inv_decision_filter;

    localparam int P_SETTLE = 16;
    localparam int P_WIN    = 16;
    localparam int P_LOCK   = 4;
    localparam int NR       = 3000;

    logic CLK;
    logic RST;
    inv_decision_filter_if bus ();

    inv_decision_filter #(
        .WIN_BITS (4),
        .SETTLE   (P_SETTLE),
        .LOCK_CNT (P_LOCK)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Directed vector: inputs applied in cycle cyc, outputs expected in that cycle.
    typedef struct {
        bit         start;   // reset first, cycle count restarts at 0
        int         cyc;
        bit         rst;
        bit         en;
        bit         ru;
        bit         rd;
        bit [3:0]   e;       // {O_INVU, O_INVD, STEP, LOCKED}
        bit [95:0]  nm;
    } vec_t;

    vec_t tbl[$];

    // Random-run stimulus and reference expectations.
    bit raw_u [NR];
    bit raw_d [NR];
    bit rl    [NR];
    bit m_o   [NR];
    bit m_st  [NR];
    bit m_lk  [NR];

    function automatic vec_t mk(bit st, int cyc, bit rst, bit en, bit ru, bit rd,
                                bit [3:0] e, bit [95:0] nm);
        vec_t v;
        v.start = st; v.cyc = cyc; v.rst = rst; v.en = en;
        v.ru = ru; v.rd = rd; v.e = e; v.nm = nm;
        return v;
    endfunction

    function automatic bit [3:0] outs();
        return {bus.O_INVU, bus.O_INVD, bus.STEP, bus.LOCKED};
    endfunction

    task automatic chk(bit [95:0] nm, bit [3:0] act, bit [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %0s: got {u,d,step,lock}=%b expected %b", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.ENABLE = 1'b1; bus.RELOCK = 1'b0;
        bus.RAW_INVU = 1'b0; bus.RAW_INVD = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    // Alternating pattern aligned to the 34-cycle period: first window votes INVD.
    task automatic drive_alt(int c);
        bit dside;
        dside = (((c + 20) / 34) % 2) == 1;
        bus.RAW_INVU = !dside;
        bus.RAW_INVD = dside;
    endtask

    function automatic void fill(int a, int b, bit o, bit lk);
        for (int i = a; i <= b && i < NR; i++) begin
            m_o[i] = o; m_lk[i] = lk;
        end
    endfunction

    function automatic void gen_random();
        int c, len, mode, prev;
        c = 0; prev = 0;
        while (c < NR) begin
            if ($urandom_range(1, 0) == 1 && prev < 2) begin
                len = 34; mode = 1 - prev;
            end else begin
                len = $urandom_range(40, 8); mode = $urandom_range(3, 0);
            end
            prev = mode;
            for (int k = 0; k < len && c < NR; k++) begin
                case (mode)
                    0: begin raw_u[c] = 1'b1; raw_d[c] = 1'b0; end
                    1: begin raw_u[c] = 1'b0; raw_d[c] = 1'b1; end
                    2: begin raw_u[c] = 1'($urandom_range(1, 0)); raw_d[c] = 1'($urandom_range(1, 0)); end
                    default: begin raw_u[c] = 1'($urandom_range(1, 0)); raw_d[c] = raw_u[c]; end
                endcase
                rl[c] = ($urandom_range(59, 0) == 0);
                c++;
            end
        end
    endfunction

    // Window-level model: walk settle/window/decide segments and fill the
    // expected outputs per cycle. Samples in cycle s reflect raw from s-2.
    function automatic void build_model();
        int c, s, d, u, dn, r, rev, next_c;
        bit dec, pv, nd;
        for (int i = 0; i < NR; i++) begin m_o[i] = 1'b1; m_st[i] = 1'b0; m_lk[i] = 1'b0; end
        dec = 1'b1; pv = 1'b0; rev = 0; c = 0;
        while (c < NR) begin
            s = c + P_SETTLE;
            fill(c, s - 1, dec, 1'b0);
            next_c = NR;
            while (s < NR) begin
                d = s + P_WIN;
                fill(s, d, dec, 1'b0);
                if (d >= NR) break;
                u = 0; dn = 0;
                for (int k = s - 2; k < d - 2; k++) begin
                    u += int'(raw_u[k]); dn += int'(raw_d[k]);
                end
                if (u == dn) begin
                    s = d + 1;
                    continue;
                end
                nd  = (u > dn);
                rev = (pv && nd != dec) ? rev + 1 : 0;
                pv  = 1'b1;
                dec = nd;
                if (rev == P_LOCK) begin
                    r = d + 1;
                    while (r < NR && !rl[r]) r++;
                    fill(d + 1, r, dec, 1'b1);
                    rev = 0; pv = 1'b0;
                    next_c = r + 1;
                end else begin
                    fill(d + 1, d + 1, dec, 1'b0);
                    if (d + 1 < NR) m_st[d + 1] = 1'b1;
                    next_c = d + 2;
                end
                break;
            end
            c = next_c;
        end
    endfunction

    initial begin
        int cyc, k;
        bit eo, est, elk;

        // ---- directed vector table ----
        // 1: INVU held -> stays 10, STEP every 34 cycles
        tbl.push_back(mk(1, 0,   0, 1, 1, 0, 4'b1000, "t1_reset"));
        tbl.push_back(mk(0, 32,  0, 1, 1, 0, 4'b1000, "t1_decide"));
        tbl.push_back(mk(0, 33,  0, 1, 1, 0, 4'b1010, "t1_step33"));
        tbl.push_back(mk(0, 34,  0, 1, 1, 0, 4'b1000, "t1_step_off"));
        tbl.push_back(mk(0, 67,  0, 1, 1, 0, 4'b1010, "t1_step67"));
        tbl.push_back(mk(0, 100, 0, 1, 1, 0, 4'b1000, "t1_c100"));
        tbl.push_back(mk(0, 101, 0, 1, 1, 0, 4'b1010, "t1_step101"));
        // 2: INVD held -> 01 from cycle 33, no lock after repeats
        tbl.push_back(mk(1, 0,   0, 1, 0, 1, 4'b1000, "t2_reset"));
        tbl.push_back(mk(0, 32,  0, 1, 0, 1, 4'b1000, "t2_pre"));
        tbl.push_back(mk(0, 33,  0, 1, 0, 1, 4'b0110, "t2_flip"));
        tbl.push_back(mk(0, 66,  0, 1, 0, 1, 4'b0100, "t2_hold"));
        tbl.push_back(mk(0, 67,  0, 1, 0, 1, 4'b0110, "t2_step67"));
        tbl.push_back(mk(0, 169, 0, 1, 0, 1, 4'b0110, "t2_nolock"));
        // 4: tie window, then INVD window decided 17 cycles later
        tbl.push_back(mk(1, 0,   0, 1, 1, 1, 4'b1000, "t4_reset"));
        tbl.push_back(mk(0, 31,  0, 1, 0, 1, 4'b1000, "t4_tie_win"));
        tbl.push_back(mk(0, 33,  0, 1, 0, 1, 4'b1000, "t4_nostep"));
        tbl.push_back(mk(0, 49,  0, 1, 0, 1, 4'b1000, "t4_decide49"));
        tbl.push_back(mk(0, 50,  0, 1, 0, 1, 4'b0110, "t4_step50"));
        // 5: ENABLE low cycles 25..29
        tbl.push_back(mk(1, 0,   0, 1, 0, 1, 4'b1000, "t5_reset"));
        tbl.push_back(mk(0, 25,  0, 0, 0, 1, 4'b1000, "t5_en_off"));
        tbl.push_back(mk(0, 30,  0, 1, 0, 1, 4'b1000, "t5_en_on"));
        tbl.push_back(mk(0, 33,  0, 1, 0, 1, 4'b1000, "t5_nostep"));
        tbl.push_back(mk(0, 62,  0, 1, 0, 1, 4'b1000, "t5_decide62"));
        tbl.push_back(mk(0, 63,  0, 1, 0, 1, 4'b0110, "t5_step63"));
        // 6: reset during STEP cycle
        tbl.push_back(mk(1, 0,   0, 1, 0, 1, 4'b1000, "t6_reset"));
        tbl.push_back(mk(0, 33,  1, 1, 0, 1, 4'b0110, "t6_in_step"));
        tbl.push_back(mk(0, 34,  0, 1, 0, 1, 4'b1000, "t6_after_rst"));
        tbl.push_back(mk(0, 66,  0, 1, 0, 1, 4'b1000, "t6_c66"));
        tbl.push_back(mk(0, 67,  0, 1, 0, 1, 4'b0110, "t6_step67"));

        cyc = 0;
        foreach (tbl[i]) begin
            if (tbl[i].start) begin
                do_reset();
                cyc = 0;
            end
            while (cyc < tbl[i].cyc) begin
                @(posedge CLK); #1;
                cyc++;
            end
            RST = tbl[i].rst;
            bus.ENABLE = tbl[i].en;
            bus.RAW_INVU = tbl[i].ru;
            bus.RAW_INVD = tbl[i].rd;
            @(negedge CLK);
            chk(tbl[i].nm, outs(), tbl[i].e);
        end

        // ---- 3: alternating decisions until lock, then RELOCK ----
        do_reset();
        for (int c = 0; c < 250; c++) begin
            if (c > 0) begin @(posedge CLK); #1; end
            drive_alt(c);
            @(negedge CLK);
            k   = (c < 33) ? -1 : (((c - 33) / 34) > 4 ? 4 : (c - 33) / 34);
            eo  = (k < 0) ? 1'b1 : ((k % 2) == 1);
            est = (c == 33 || c == 67 || c == 101 || c == 135);
            elk = (c >= 169);
            chk("t3_alt", outs(), {eo, !eo, est, elk});
        end
        @(posedge CLK); #1;                       // cycle 250
        bus.RELOCK = 1'b1; bus.RAW_INVU = 1'b1; bus.RAW_INVD = 1'b0;
        @(negedge CLK);
        chk("t3_pre_rlk", outs(), 4'b0101);
        @(posedge CLK); #1;                       // cycle 251
        bus.RELOCK = 1'b0;
        @(negedge CLK);
        chk("t3_relocked", outs(), 4'b0100);
        repeat (32) begin @(posedge CLK); #1; end // cycle 283
        @(negedge CLK);
        chk("t3_rs_dec", outs(), 4'b0100);
        @(posedge CLK); #1;                       // cycle 284
        @(negedge CLK);
        chk("t3_rs_step", outs(), 4'b1010);

        // ---- reset while locked ----
        do_reset();
        for (int c = 0; c < 180; c++) begin
            if (c > 0) begin @(posedge CLK); #1; end
            drive_alt(c);
        end
        @(posedge CLK); #1;                       // cycle 180
        RST = 1'b1;
        @(negedge CLK);
        chk("t6_locked", outs(), 4'b0101);
        @(posedge CLK); #1;                       // cycle 181 = new cycle 0
        RST = 1'b0; bus.RAW_INVU = 1'b0; bus.RAW_INVD = 1'b1;
        @(negedge CLK);
        chk("t6_rst_lock", outs(), 4'b1000);
        repeat (32) begin @(posedge CLK); #1; end
        @(negedge CLK);
        chk("t6_lk_c32", outs(), 4'b1000);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("t6_lk_c33", outs(), 4'b0110);

        // ---- randomized run against the window model ----
        gen_random();
        build_model();
        do_reset();
        for (int c = 0; c < NR; c++) begin
            if (c > 0) begin @(posedge CLK); #1; end
            bus.RAW_INVU = raw_u[c];
            bus.RAW_INVD = raw_d[c];
            bus.RELOCK   = rl[c];
            @(negedge CLK);
            chk("rand", outs(), {m_o[c], !m_o[c], m_st[c], m_lk[c]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
